// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch path.
package fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/le_word_assembler.sv
// Collects byte returns into a 32-bit little-endian word, one lane per write.
module le_word_assembler
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        wr_data,
    output logic [31:0]       word
);

    logic [7:0] lanes [WORD_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_BYTES; i++) lanes[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < WORD_BYTES; i++) lanes[i] <= '0;
        end else if (wr_en) begin
            lanes[lane] <= wr_data;
        end
    end

    // The lane being written shows through immediately, so the final byte can be captured on arrival.
    always_comb begin
        word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            word[8*i +: 8] = (wr_en && !clear && lane == LANE_W'(i)) ? wr_data : lanes[i];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches one 32-bit instruction as four byte reads, hands it to decode, and follows redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misalign_err
);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [LANE_W-1:0]   byte_idx;
    logic [LANE_W-1:0]   rd_idx;
    logic                rd_pending;
    logic [31:0]         asm_word;
    logic                redirect_aligned;
    logic                asm_wr_en;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
    assign asm_wr_en        = rd_pending && !redirect_valid;

    le_word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (redirect_valid),
        .wr_en   (asm_wr_en),
        .lane    (rd_idx),
        .wr_data (mem_rdata),
        .word    (asm_word)
    );

    // A redirect overrides everything, including a same-cycle handshake's pc+4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            byte_idx     <= '0;
            rd_idx       <= '0;
            rd_pending   <= 1'b0;
            mem_en       <= 1'b0;
            mem_addr     <= '0;
            inst_valid   <= 1'b0;
            inst_data    <= '0;
            inst_pc      <= '0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
            byte_idx   <= '0;
            rd_pending <= 1'b0;
            if (redirect_aligned) begin
                pc           <= redirect_pc;
                misalign_err <= 1'b0;
                state        <= FETCH;
                mem_en       <= 1'b1;
                mem_addr     <= redirect_pc;
            end else begin
                misalign_err <= 1'b1;
                state        <= ERR;
                mem_en       <= 1'b0;
            end
        end else begin
            rd_pending <= mem_en;
            rd_idx     <= byte_idx;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    mem_en   <= 1'b1;
                    mem_addr <= pc;
                    byte_idx <= '0;
                end
                FETCH: begin
                    if (byte_idx == LANE_W'(WORD_BYTES - 1)) begin
                        mem_en   <= 1'b0;
                        byte_idx <= '0;
                        state    <= WAIT;
                    end else begin
                        byte_idx <= byte_idx + LANE_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                WAIT: begin
                    inst_data  <= asm_word;
                    inst_pc    <= pc;
                    inst_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc         <= pc + ADDR_W'(WORD_BYTES);
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                        mem_en     <= 1'b1;
                        mem_addr   <= pc + ADDR_W'(WORD_BYTES);
                        byte_idx   <= '0;
                    end
                end
                ERR: begin
                    mem_en     <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer against a 16-byte instruction memory model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misalign_err;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t exp_item;

    logic [7:0] mem_bytes [16];
    int passed = 0;
    int total  = 0;
    int xfer_count = 0;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Byte memory answers one cycle after a request; junk otherwise.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_bytes[mem_addr % 32'd16];
        else        mem_rdata <= 8'hEE;
    end

    always @(posedge clk) begin
        if (rst_n && inst_valid && inst_ready) xfer_count <= xfer_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset(input logic ready_val);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = ready_val;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en && mem_addr == addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_en, mem_addr, inst_valid, inst_data, inst_pc, misalign_err} !== 99'd0)
            $display("[TB] FAIL reset_outputs got en=%b addr=%h v=%b d=%h pc=%h err=%b want all 0",
                     mem_en, mem_addr, inst_valid, inst_data, inst_pc, misalign_err);
        else passed++;
    endtask

    task automatic test_sequential_fetch();
        int  cycles;
        bit  ok;
        logic [31:0] words [4];
        words[0] = 32'hFFC4A303; words[1] = 32'h0064A423;
        words[2] = 32'h0062E233; words[3] = 32'hFE420AE3;
        for (int i = 0; i < 4; i++) sb.push_back('{data: words[i], pc: 32'(4 * i)});
        apply_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (mem_en !== 1'b1 || mem_addr !== 32'(k))
                $display("[TB] FAIL seq_addr%0d got en=%b addr=%h want en=1 addr=%h", k, mem_en, mem_addr, k);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (inst_valid !== 1'b0 || mem_en !== 1'b0)
            $display("[TB] FAIL seq_wait got v=%b en=%b want v=0 en=0", inst_valid, mem_en);
        else passed++;
        @(negedge clk);
        exp_item = sb.pop_front();
        total++;
        if (inst_valid !== 1'b1 || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL seq_inst0 got v=%b %h@%h want v=1 %h@%h",
                     inst_valid, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            wait_valid(20, cycles, ok);
            exp_item = sb.pop_front();
            total++;
            if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
                $display("[TB] FAIL seq_inst%0d got ok=%b %h@%h want %h@%h",
                         i, ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
            else passed++;
            total++;
            if (cycles !== 6)
                $display("[TB] FAIL seq_throughput%0d got %0d cycles want 6", i, cycles);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int cycles;
        bit ok;
        sb.push_back('{data: 32'hFFC4A303, pc: 32'h0});
        apply_reset(1'b0);
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL bp_inst0 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (inst_valid !== 1'b1 || mem_en !== 1'b0 || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
                $display("[TB] FAIL bp_hold%0d got v=%b en=%b %h@%h want v=1 en=0 %h@%h",
                         i, inst_valid, mem_en, inst_data, inst_pc, exp_item.data, exp_item.pc);
            else passed++;
        end
        inst_ready = 1'b1;
        sb.push_back('{data: 32'h0064A423, pc: 32'h4});
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h4 || inst_valid !== 1'b0)
            $display("[TB] FAIL bp_next_addr got en=%b addr=%h v=%b want en=1 addr=4 v=0", mem_en, mem_addr, inst_valid);
        else passed++;
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL bp_inst1 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
    endtask

    task automatic test_redirect_mid_fetch();
        int cycles;
        bit ok;
        apply_reset(1'b0);
        wait_addr(32'h2, ok);
        total++;
        if (!ok) $display("[TB] FAIL rd_reach_byte2 got timeout want mem_addr=2");
        else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        sb.push_back('{data: 32'hFE420AE3, pc: 32'hC});
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 32'hC || inst_valid !== 1'b0)
            $display("[TB] FAIL rd_target_addr got en=%b addr=%h v=%b want en=1 addr=c v=0", mem_en, mem_addr, inst_valid);
        else passed++;
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc || cycles !== 5)
            $display("[TB] FAIL rd_inst got ok=%b %h@%h after %0d want %h@%h after 5",
                     ok, inst_data, inst_pc, cycles, exp_item.data, exp_item.pc);
        else passed++;
    endtask

    task automatic test_misaligned();
        int cycles;
        bit ok;
        sb.push_back('{data: 32'hFFC4A303, pc: 32'h0});
        apply_reset(1'b0);
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL mis_inst0 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (misalign_err !== 1'b1 || mem_en !== 1'b0 || inst_valid !== 1'b0)
                $display("[TB] FAIL mis_err%0d got err=%b en=%b v=%b want err=1 en=0 v=0", i, misalign_err, mem_en, inst_valid);
            else passed++;
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        sb.push_back('{data: 32'h0064A423, pc: 32'h4});
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (misalign_err !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h4)
            $display("[TB] FAIL mis_recover got err=%b en=%b addr=%h want err=0 en=1 addr=4", misalign_err, mem_en, mem_addr);
        else passed++;
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL mis_inst1 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
    endtask

    task automatic test_redirect_with_transfer();
        int cycles;
        bit ok;
        int xfer_base;
        sb.push_back('{data: 32'hFFC4A303, pc: 32'h0});
        apply_reset(1'b0);
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL rt_inst0 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
        xfer_base      = xfer_count;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        sb.push_back('{data: 32'h0062E233, pc: 32'h8});
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || mem_addr !== 32'h8)
            $display("[TB] FAIL rt_target got v=%b addr=%h want v=0 addr=8", inst_valid, mem_addr);
        else passed++;
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc)
            $display("[TB] FAIL rt_inst1 got ok=%b %h@%h want %h@%h", ok, inst_data, inst_pc, exp_item.data, exp_item.pc);
        else passed++;
        total++;
        if (xfer_count - xfer_base !== 1)
            $display("[TB] FAIL rt_consumed_once got %0d transfers want 1", xfer_count - xfer_base);
        else passed++;
    endtask

    task automatic test_async_reset();
        int cycles;
        bit ok;
        apply_reset(1'b1);
        wait_addr(32'h2, ok);
        total++;
        if (!ok) $display("[TB] FAIL ar_reach_byte2 got timeout want mem_addr=2");
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_en, mem_addr, inst_valid, inst_data, inst_pc, misalign_err} !== 99'd0)
            $display("[TB] FAIL ar_immediate got en=%b addr=%h v=%b d=%h pc=%h err=%b want all 0",
                     mem_en, mem_addr, inst_valid, inst_data, inst_pc, misalign_err);
        else passed++;
        repeat (2) @(negedge clk);
        sb.push_back('{data: 32'hFFC4A303, pc: 32'h0});
        rst_n = 1'b1;
        wait_valid(20, cycles, ok);
        exp_item = sb.pop_front();
        total++;
        if (!ok || inst_data !== exp_item.data || inst_pc !== exp_item.pc || cycles !== 6)
            $display("[TB] FAIL ar_restart got ok=%b %h@%h after %0d want %h@%h after 6",
                     ok, inst_data, inst_pc, cycles, exp_item.data, exp_item.pc);
        else passed++;
    endtask

    initial begin
        mem_bytes[0]  = 8'h03; mem_bytes[1]  = 8'hA3; mem_bytes[2]  = 8'hC4; mem_bytes[3]  = 8'hFF;
        mem_bytes[4]  = 8'h23; mem_bytes[5]  = 8'hA4; mem_bytes[6]  = 8'h64; mem_bytes[7]  = 8'h00;
        mem_bytes[8]  = 8'h33; mem_bytes[9]  = 8'hE2; mem_bytes[10] = 8'h62; mem_bytes[11] = 8'h00;
        mem_bytes[12] = 8'hE3; mem_bytes[13] = 8'h0A; mem_bytes[14] = 8'h42; mem_bytes[15] = 8'hFE;

        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_redirect_mid_fetch();
        test_misaligned();
        test_redirect_with_transfer();
        test_async_reset();

        total++;
        if (sb.size() !== 0)
            $display("[TB] FAIL scoreboard_drain got %0d entries want 0", sb.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
